// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU parallel bus receiver: opcodes, receive modes and
// the layout of the status byte returned to the MCU.
package mcu_bus_pkg;

  localparam logic [7:0] CMD_NOP         = 8'h00;
  localparam logic [7:0] CMD_SET_ADDRESS = 8'h01;
  localparam logic [7:0] CMD_WRITE       = 8'h02;

  typedef enum logic [1:0] {
    ModeIdle  = 2'd0,
    ModeAddr  = 2'd1,
    ModeWrite = 2'd2
  } mode_e;

  localparam int unsigned STAT_ADDR_BIT  = 0;
  localparam int unsigned STAT_WRITE_BIT = 1;
  localparam int unsigned STAT_IDX_LSB   = 2;
  localparam int unsigned STAT_ERR_BIT   = 7;

  function automatic logic [7:0] pack_status(mode_e mode, logic [1:0] idx, logic err);
    logic [7:0] s;
    s                      = '0;
    s[STAT_ADDR_BIT]       = (mode == ModeAddr);
    s[STAT_WRITE_BIT]      = (mode == ModeWrite);
    s[STAT_IDX_LSB +: 2]   = idx;
    s[STAT_ERR_BIT]        = err;
    return s;
  endfunction

endpackage

// File: rtl/mcu_bus_sync.sv
// Synchronises busclk, bus_in and command_data into sysclk and emits a one-cycle
// strobe per busclk rise together with the byte and command flag aligned to that rise.
module mcu_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       busclk,
  input  logic [7:0] bus_in,
  input  logic       command_data,
  output logic [7:0] sync_byte,
  output logic       sync_cmd,
  output logic       sync_strobe
);

  logic [SYNC_STAGES-1:0]      clk_sync_q;
  logic [SYNC_STAGES-1:0][8:0] data_sync_q;
  logic                        clk_hist_q;
  logic                        strobe_q;
  logic [8:0]                  word_q;
  logic                        rise;

  assign rise = clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;

  // busclk stages reset high so a strobe already high at reset release is not an edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '0;
      clk_hist_q  <= 1'b1;
      strobe_q    <= 1'b0;
      word_q      <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], busclk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], {command_data, bus_in}};
      clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
      strobe_q    <= rise;
      if (rise) begin
        word_q <= data_sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign sync_strobe = strobe_q;
  assign sync_cmd    = word_q[8];
  assign sync_byte   = word_q[7:0];

endmodule

// File: rtl/mcu_bus_receiver.sv
// Slave-side MCU bus receiver: decodes command/data bytes, tracks the write address
// and strobes each byte out to the downstream broker.
module mcu_bus_receiver
  import mcu_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              busclk,
  input  logic [7:0]        bus_in,
  input  logic              command_data,
  output logic [7:0]        bus_out,
  output logic              dataclk,
  output logic              cmdclk,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_out
);

  logic [7:0] sync_byte;
  logic       sync_cmd;
  logic       sync_strobe;

  mcu_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .busclk       (busclk),
    .bus_in       (bus_in),
    .command_data (command_data),
    .sync_byte    (sync_byte),
    .sync_cmd     (sync_cmd),
    .sync_strobe  (sync_strobe)
  );

  mode_e             mode_q, mode_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        data_q, data_d;
  logic              cmdclk_q, cmdclk_d;
  logic              dataclk_q, dataclk_d;
  logic              inc_q, inc_d;
  logic [7:0]        status_q;
  logic [ADDR_W-1:0] shadow_shift;

  assign shadow_shift = {shadow_q[ADDR_W-9:0], sync_byte};

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      mode_q    <= ModeIdle;
      idx_q     <= '0;
      shadow_q  <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      cmdclk_q  <= 1'b0;
      dataclk_q <= 1'b0;
      inc_q     <= 1'b0;
      status_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      data_q    <= data_d;
      cmdclk_q  <= cmdclk_d;
      dataclk_q <= dataclk_d;
      inc_q     <= inc_d;
      status_q  <= pack_status(mode_d, idx_d, err_d);
    end
  end

  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    addr_d    = addr_q;
    err_d     = err_q;
    data_d    = data_q;
    cmdclk_d  = 1'b0;
    dataclk_d = 1'b0;
    inc_d     = 1'b0;

    // Address advances the cycle after the data pulse so the pulse sees the target.
    if (inc_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (sync_strobe) begin
      data_d = sync_byte;
      if (sync_cmd) begin
        cmdclk_d = 1'b1;
        idx_d    = '0;
        case (sync_byte)
          CMD_NOP: mode_d = ModeIdle;
          CMD_SET_ADDRESS: begin
            mode_d   = ModeAddr;
            shadow_d = '0;
            err_d    = 1'b0;
          end
          CMD_WRITE: mode_d = ModeWrite;
          default: begin
            mode_d = ModeIdle;
            err_d  = 1'b1;
          end
        endcase
      end else begin
        unique case (mode_q)
          ModeAddr: begin
            shadow_d = shadow_shift;
            if (idx_q == 2'd3) begin
              addr_d = shadow_shift;
              mode_d = ModeWrite;
              idx_d  = '0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
          ModeWrite: begin
            dataclk_d = 1'b1;
            inc_d     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_out  = status_q;
  assign dataclk  = dataclk_q;
  assign cmdclk   = cmdclk_q;
  assign address  = addr_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mcu_bus_receiver.sv
// Self-checking bench for mcu_bus_receiver: directed scenarios plus random bytes
// compared against a byte-level model of the protocol.
module tb_mcu_bus_receiver;

  localparam int unsigned SS = 2;

  logic        sysclk;
  logic        rst_n;
  logic        busclk;
  logic [7:0]  bus_in;
  logic        command_data;
  logic [7:0]  bus_out;
  logic        dataclk;
  logic        cmdclk;
  logic [31:0] address;
  logic [7:0]  data_out;

  mcu_bus_receiver #(
    .SYNC_STAGES (SS),
    .ADDR_W      (32)
  ) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .busclk       (busclk),
    .bus_in       (bus_in),
    .command_data (command_data),
    .bus_out      (bus_out),
    .dataclk      (dataclk),
    .cmdclk       (cmdclk),
    .address      (address),
    .data_out     (data_out)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse counters observed on the DUT.
  int n_cmd_seen  = 0;
  int n_dat_seen  = 0;
  int n_both_seen = 0;
  always @(negedge sysclk) begin
    if (cmdclk) n_cmd_seen++;
    if (dataclk) n_dat_seen++;
    if (cmdclk && dataclk) n_both_seen++;
  end

  // Byte-level protocol model.
  int          m_mode;  // 0 idle, 1 collecting address, 2 write
  int          m_idx;
  logic [31:0] m_shadow;
  logic [31:0] m_addr;
  int          m_err;
  int          exp_cmd_cnt;
  int          exp_dat_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_idx    = 0;
    m_shadow = 0;
    m_addr   = 0;
    m_err    = 0;
  endtask

  function automatic logic [7:0] model_status();
    return 8'((m_err != 0 ? 128 : 0) + m_idx * 4 + (m_mode == 2 ? 2 : 0) + (m_mode == 1 ? 1 : 0));
  endfunction

  // Drives one byte with minimum-width busclk phases and checks the resulting strobe.
  task automatic send_byte(input logic cmd, input logic [7:0] b);
    logic        e_cmd, e_dat;
    logic [31:0] a_pulse, a_after;
    e_cmd = cmd;
    e_dat = 1'b0;
    if (cmd) begin
      m_idx = 0;
      if (b == 8'h00) m_mode = 0;
      else if (b == 8'h01) begin
        m_mode = 1; m_shadow = 0; m_err = 0;
      end else if (b == 8'h02) m_mode = 2;
      else begin
        m_mode = 0; m_err = 1;
      end
      a_pulse = m_addr;
      a_after = m_addr;
    end else if (m_mode == 1) begin
      m_shadow = (m_shadow << 8) | 32'(b);
      m_idx++;
      if (m_idx == 4) begin
        m_addr = m_shadow; m_mode = 2; m_idx = 0;
      end
      a_pulse = m_addr;
      a_after = m_addr;
    end else if (m_mode == 2) begin
      e_dat   = 1'b1;
      a_pulse = m_addr;
      m_addr  = m_addr + 1;
      a_after = m_addr;
    end else begin
      a_pulse = m_addr;
      a_after = m_addr;
    end
    if (e_cmd) exp_cmd_cnt++;
    if (e_dat) exp_dat_cnt++;

    @(negedge sysclk);
    bus_in = b;
    command_data = cmd;
    @(negedge sysclk);
    busclk = 1'b1;
    for (int k = 0; k <= SS; k++) begin
      @(posedge sysclk);
      #1;
      if (k == SS) check("strobe_early", 32'({cmdclk, dataclk}), 32'b00);
    end
    @(negedge sysclk);
    busclk = 1'b0;
    @(posedge sysclk);
    #1;
    check("strobe_at_latency", 32'({cmdclk, dataclk}), 32'({e_cmd, e_dat}));
    check("data_out", 32'(data_out), 32'(b));
    check("addr_at_pulse", address, a_pulse);
    @(posedge sysclk);
    #1;
    check("strobe_one_cycle", 32'({cmdclk, dataclk}), 32'b00);
    check("addr_after", address, a_after);
    check("bus_out", 32'(bus_out), 32'(model_status()));
    repeat (SS - 1 + $urandom_range(0, 3)) @(posedge sysclk);
    #1;
    bus_in = 8'($urandom);
    command_data = 1'($urandom);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rc;
    rst_n = 1'b0;
    busclk = 1'b1;
    bus_in = 8'h00;
    command_data = 1'b0;
    model_reset();
    exp_cmd_cnt = 0;
    exp_dat_cnt = 0;

    // Reset with busclk held high: release must not create an edge.
    repeat (4) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (8) @(negedge sysclk);
    check("rst_address", address, 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_bus_out", 32'(bus_out), 32'h0);
    check("rst_no_strobe", 32'(n_cmd_seen + n_dat_seen), 32'd0);
    busclk = 1'b0;
    repeat (SS + 1) @(negedge sysclk);

    // Address load then one write.
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    send_byte(1'b0, 8'h56);
    send_byte(1'b0, 8'h78);
    check("dir_addr_loaded", address, 32'h1234_5678);
    check("dir_status_write", 32'(bus_out), 32'h02);
    send_byte(1'b0, 8'hAB);
    check("dir_addr_incr", address, 32'h1234_5679);

    // Address wrap.
    send_byte(1'b1, 8'h01);
    repeat (4) send_byte(1'b0, 8'hFF);
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    check("dir_addr_wrap", address, 32'h0000_0001);

    // Aborted address collection.
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    send_byte(1'b1, 8'h00);
    check("dir_abort_addr", address, 32'h0000_0001);
    check("dir_abort_status", 32'(bus_out), 32'h00);

    // Invalid command sets error, SET_ADDRESS clears it.
    send_byte(1'b1, 8'h7F);
    check("dir_err_set", 32'(bus_out[7]), 32'd1);
    send_byte(1'b0, 8'h55);
    send_byte(1'b1, 8'h01);
    check("dir_err_clear", 32'(bus_out), 32'h01);

    // Random traffic, biased towards valid opcodes.
    for (int i = 0; i < 200; i++) begin
      rc = ($urandom_range(0, 3) == 0);
      if (rc) rb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
      else rb = 8'($urandom);
      send_byte(rc, rb);
    end

    // Reset while a byte is in flight: no strobe, state cleared.
    send_byte(1'b1, 8'h01);
    send_byte(1'b0, 8'hC3);
    @(negedge sysclk);
    bus_in = 8'h9C;
    command_data = 1'b1;
    @(negedge sysclk);
    busclk = 1'b1;
    @(negedge sysclk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    check("midrst_address", address, 32'h0);
    check("midrst_bus_out", 32'(bus_out), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    busclk = 1'b0;
    repeat (SS + 1) @(negedge sysclk);
    send_byte(1'b0, 8'h3C);
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'h5A);

    repeat (4) @(negedge sysclk);
    check("cmdclk_count", 32'(n_cmd_seen), 32'(exp_cmd_cnt));
    check("dataclk_count", 32'(n_dat_seen), 32'(exp_dat_cnt));
    check("never_both", 32'(n_both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
